// File: rtl/id_pkg.sv
// id_pkg: shared constants for the instruction-decode stage.
//   - Default operand/register widths (DATA_W_DEF, ADDR_W_DEF)
//   - Supported MIPS-subset opcode values
//   - Bit positions of the instruction fields
//   - Helper for selecting zero- vs sign-extension of the immediate
package id_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Low bit of each field; widths are fixed by the instruction format.
  localparam int OPC_LO   = 26;
  localparam int RS_LO    = 21;
  localparam int RT_LO    = 16;
  localparam int RD_LO    = 11;
  localparam int FUNCT_LO = 0;
  localparam int IMM_LO   = 0;

  // Logical immediates (andi/ori) are zero-extended; everything else is signed.
  function automatic logic imm_is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: one busy bit per architectural register.
//   clk, rst            : clock, synchronous active-high reset (clears all bits)
//   set_en_i/set_addr_i : mark a register as having a producer in flight
//   clr_en_i/clr_addr_i : write-back retired the producer of a register
//   rs_addr_i/rs_busy_o, rt_addr_i/rt_busy_o, dst_addr_i/dst_busy_o
//                       : combinational lookups of the current busy state
// A set and a clear of the same bit in one cycle leaves the bit set, since
// the set belongs to a newer producer. Bit 0 never becomes busy.
module id_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  output logic              dst_busy_o
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: set has priority over clear; r0 pinned to zero.
  always_comb begin
    busy_d = '0;
    for (int i = 1; i < NREG; i++) begin
      if (set_en_i && (set_addr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_en_i && (clr_addr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs_busy_o  = busy_q[rs_addr_i];
  assign rt_busy_o  = busy_q[rt_addr_i];
  assign dst_busy_o = busy_q[dst_addr_i];

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS-subset instruction decode with busy-scoreboard hazard stall
// and an ID/EX output register behind a valid/ready handshake.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready/in_instr : upstream instruction handshake
//   raddr1/raddr2              : register-file read addresses (rs, rt)
//   rdata1/rdata2              : register-file combinational read data
//   wb_we/wb_waddr/wb_wdata    : snooped register-file write port
//   out_valid/out_ready        : downstream handshake
//   out_rs_val/out_rt_val      : source operands
//   out_imm                    : extended immediate
//   out_opcode/out_funct       : raw opcode and funct fields
//   out_dst/out_dst_we         : destination register and write flag
//   out_illegal                : unsupported opcode
// Build option: define ID_WB_BYPASS_EN to forward same-cycle write-back data
// into the operands and drop the corresponding RAW stall by one cycle.
module id_stage import id_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [ADDR_W-1:0] out_dst,
  output logic              out_dst_we,
  output logic              out_illegal
);

  logic [5:0]        opcode_s;
  logic [5:0]        funct_s;
  logic [ADDR_W-1:0] rs_s, rt_s, rd_s;
  logic [15:0]       imm16_s;

  assign opcode_s = in_instr[OPC_LO +: 6];
  assign funct_s  = in_instr[FUNCT_LO +: 6];
  assign rs_s     = in_instr[RS_LO +: ADDR_W];
  assign rt_s     = in_instr[RT_LO +: ADDR_W];
  assign rd_s     = in_instr[RD_LO +: ADDR_W];
  assign imm16_s  = in_instr[IMM_LO +: 16];

  assign raddr1 = rs_s;
  assign raddr2 = rt_s;

  logic              uses_rs_s, uses_rt_s, has_dst_s, illegal_s;
  logic [ADDR_W-1:0] dst_s;
  logic              dst_we_s;
  logic [DATA_W-1:0] imm_s;

  // Opcode decode: which sources are read and where the result goes.
  always_comb begin
    uses_rs_s = 1'b0;
    uses_rt_s = 1'b0;
    has_dst_s = 1'b0;
    illegal_s = 1'b0;
    dst_s     = '0;
    case (opcode_s)
      OP_RTYPE: begin
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
        has_dst_s = 1'b1;
        dst_s     = rd_s;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        uses_rs_s = 1'b1;
        has_dst_s = 1'b1;
        dst_s     = rt_s;
      end
      OP_SW, OP_BEQ: begin
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  assign dst_we_s = has_dst_s && (dst_s != '0);
  assign imm_s    = imm_is_zext(opcode_s) ? {{(DATA_W-16){1'b0}}, imm16_s}
                                          : {{(DATA_W-16){imm16_s[15]}}, imm16_s};

  logic accept_s;
  logic rs_busy_s, rt_busy_s, dst_busy_s;

  id_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (accept_s && dst_we_s),
    .set_addr_i (dst_s),
    .clr_en_i   (wb_we),
    .clr_addr_i (wb_waddr),
    .rs_addr_i  (rs_s),
    .rt_addr_i  (rt_s),
    .dst_addr_i (dst_s),
    .rs_busy_o  (rs_busy_s),
    .rt_busy_o  (rt_busy_s),
    .dst_busy_o (dst_busy_s)
  );

  // A source being written back this cycle can be forwarded instead of stalling.
  logic rs_fwd_s, rt_fwd_s;
`ifdef ID_WB_BYPASS_EN
  assign rs_fwd_s = wb_we && (wb_waddr == rs_s) && (rs_s != '0);
  assign rt_fwd_s = wb_we && (wb_waddr == rt_s) && (rt_s != '0);
`else
  logic unused_wb_s;
  assign unused_wb_s = ^wb_wdata;
  assign rs_fwd_s    = 1'b0;
  assign rt_fwd_s    = 1'b0;
`endif

  logic [DATA_W-1:0] rs_val_s, rt_val_s;
  logic              hazard_s;

  assign rs_val_s = rs_fwd_s ? wb_wdata : rdata1;
  assign rt_val_s = rt_fwd_s ? wb_wdata : rdata2;

  // WAW term ignores forwarding: only one producer per register in flight.
  assign hazard_s = (uses_rs_s && rs_busy_s && !rs_fwd_s) ||
                    (uses_rt_s && rt_busy_s && !rt_fwd_s) ||
                    (dst_we_s && dst_busy_s);

  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d, imm_q, imm_d;
  logic [5:0]        opcode_q, opcode_d, funct_q, funct_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              dst_we_q, dst_we_d, illegal_q, illegal_d;

  assign in_ready = !rst && !hazard_s && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;

  // ID/EX register next state: load on accept, drain on out_ready, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    imm_d       = imm_q;
    opcode_d    = opcode_q;
    funct_d     = funct_q;
    dst_d       = dst_q;
    dst_we_d    = dst_we_q;
    illegal_d   = illegal_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      rs_val_d    = rs_val_s;
      rt_val_d    = rt_val_s;
      imm_d       = imm_s;
      opcode_d    = opcode_s;
      funct_d     = funct_s;
      dst_d       = dst_s;
      dst_we_d    = dst_we_s;
      illegal_d   = illegal_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      opcode_q    <= '0;
      funct_q     <= '0;
      dst_q       <= '0;
      dst_we_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      opcode_q    <= opcode_d;
      funct_q     <= funct_d;
      dst_q       <= dst_d;
      dst_we_q    <= dst_we_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs_val  = rs_val_q;
  assign out_rt_val  = rt_val_q;
  assign out_imm     = imm_q;
  assign out_opcode  = opcode_q;
  assign out_funct   = funct_q;
  assign out_dst     = dst_q;
  assign out_dst_we  = dst_we_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage with a small register-file
// model on the read/write ports. Handles both settings of ID_WB_BYPASS_EN.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs_val, out_rt_val, out_imm;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_dst;
  logic        out_dst_we;
  logic        out_illegal;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs_val (out_rs_val),
    .out_rt_val (out_rt_val),
    .out_imm    (out_imm),
    .out_opcode (out_opcode),
    .out_funct  (out_funct),
    .out_dst    (out_dst),
    .out_dst_we (out_dst_we),
    .out_illegal(out_illegal)
  );

  // Register-file model: writes at the clock edge, combinational reads.
  logic [31:0] regs [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (wb_we && (wb_waddr != 5'd0)) regs[wb_waddr] <= wb_wdata;
  end
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0;
    wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_dst", {27'd0, out_dst}, 32'd0);
    check("rst_rs_val", out_rs_val, 32'h0);
    check("rst_busy", dut.u_sb.busy_q, 32'h0);

    rst = 1'b0; settle();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // r1 = A5A5A5A5 via write-back
    wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'hA5A5A5A5;
    tick();
    wb_we = 1'b0;

    // add r3,r1,r2
    in_valid = 1'b1; in_instr = 32'h00221820; settle();
    check("add_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_rs_val", out_rs_val, 32'hA5A5A5A5);
    check("add_rt_val", out_rt_val, 32'h0);
    check("add_dst", {27'd0, out_dst}, 32'd3);
    check("add_dst_we", {31'd0, out_dst_we}, 32'd1);
    check("add_funct", {26'd0, out_funct}, 32'h20);
    check("add_busy", dut.u_sb.busy_q, 32'h8);

    // addi r4,r3,-1 stalls on r3
    in_valid = 1'b1; in_instr = 32'h2064FFFF; settle();
    check("addi_stall", {31'd0, in_ready}, 32'd0);
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h10; settle();
`ifdef ID_WB_BYPASS_EN
    check("addi_byp_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_we = 1'b0;
`else
    check("addi_wb_ready", {31'd0, in_ready}, 32'd0);
    tick();
    wb_we = 1'b0; settle();
    check("addi_next_ready", {31'd0, in_ready}, 32'd1);
    tick();
`endif
    in_valid = 1'b0;
    check("addi_out_valid", {31'd0, out_valid}, 32'd1);
    check("addi_rs_val", out_rs_val, 32'h10);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_dst", {27'd0, out_dst}, 32'd4);
    check("addi_opcode", {26'd0, out_opcode}, 32'h08);

    // Back-pressure: ori r5,r1,0x8001 waits while addi is held
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h34258001; settle();
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_dst", {27'd0, out_dst}, 32'd4);
      check("bp_imm", out_imm, 32'hFFFFFFFF);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; settle();
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("ori_dst", {27'd0, out_dst}, 32'd5);
    check("ori_imm_zext", out_imm, 32'h00008001);
    check("ori_rs_val", out_rs_val, 32'hA5A5A5A5);
    check("ori_busy", dut.u_sb.busy_q, 32'h30);

    // Retire r5, then lw r5,0(r1) accepted while r5 write-back happens
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h55;
    tick();
    check("r5_cleared", dut.u_sb.busy_q, 32'h10);
    in_valid = 1'b1; in_instr = 32'h8C250000; settle();
    check("lw_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_we = 1'b0;
    check("setclr_busy", dut.u_sb.busy_q, 32'h30);
    in_instr = 32'h20A60001; settle();
    check("r5_raw_stall", {31'd0, in_ready}, 32'd0);

    // addi r0,r1,5: no destination write, busy unchanged
    in_instr = 32'h20200005; settle();
    check("r0_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("r0_dst_we", {31'd0, out_dst_we}, 32'd0);
    check("r0_busy", dut.u_sb.busy_q, 32'h30);

    // Illegal opcode 0x3F with busy rs/rt fields: no stall
    in_instr = 32'hFC850000; settle();
    check("ill_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_dst_we", {31'd0, out_dst_we}, 32'd0);
    check("ill_busy", dut.u_sb.busy_q, 32'h30);

    // sw r5,4(r1) reads busy r5
    in_instr = 32'hAC250004; settle();
    check("sw_stall", {31'd0, in_ready}, 32'd0);

    // Reset while stalled on r3
    in_instr = 32'h00221820; settle();
    tick();
    in_instr = 32'h2064FFFF; settle();
    check("pre_rst_stall", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; settle();
    check("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_busy", dut.u_sb.busy_q, 32'h0);
    check("rst_mid_dst", {27'd0, out_dst}, 32'd0);
    rst = 1'b0; settle();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_dst", {27'd0, out_dst}, 32'd4);
    check("post_rst_rs_val", out_rs_val, 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
